// File: rtl/iob_timer_reader.sv
// iob_timer_reader: native-bus initiator sequencing clear/start/stop/capture register accesses on a 64-bit timer
module iob_timer_reader #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int RESET_ADDR     = 0,
  parameter int ENABLE_ADDR    = 1,
  parameter int SAMPLE_ADDR    = 2,
  parameter int DATA_LOW_ADDR  = 3,
  parameter int DATA_HIGH_ADDR = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  output logic                cmd_ready,
  output logic                done,
  output logic                err,
  output logic [2*DATA_W-1:0] ts_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] CLEAR = 2'd0, START = 2'd1, STOP = 2'd2, CAPTURE = 2'd3;
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_LO, RD_HI} state_t;
  state_t state, state_n;
  logic [1:0] op, op_n;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] lo;
  logic accept, xfer_done, wait_c, timeout, fin, load, wbit_n, rd_n;
  logic [ADDR_W-1:0] addr_n;
  assign cmd_ready = state == IDLE && !done && !err;
  assign accept    = cmd_valid && cmd_ready;
  assign xfer_done = m_valid && m_ready;
  assign wait_c    = m_valid && !m_ready;
  assign timeout   = TIMEOUT != 0 && wait_c && cnt == CW'(TIMEOUT - 1);
  assign op_n      = accept ? cmd_op : op;
  always_comb begin
    state_n = state;
    fin     = 1'b0;
    case (state)
      IDLE:  state_n = accept ? WR_A : IDLE;
      WR_A:  if (xfer_done) begin
               fin     = op == START || op == STOP;
               state_n = fin ? IDLE : WR_B;
             end
      WR_B:  if (xfer_done) begin
               fin     = op == CLEAR;
               state_n = fin ? IDLE : RD_LO;
             end
      RD_LO: if (xfer_done) state_n = RD_HI;
      RD_HI: if (xfer_done) begin
               fin     = 1'b1;
               state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end
  // Bus request for the upcoming transfer is computed from the next state so it can be registered back-to-back
  assign load   = state_n != IDLE && (accept || xfer_done);
  assign rd_n   = state_n == RD_LO || state_n == RD_HI;
  assign wbit_n = state_n == WR_A && op_n != STOP;
  assign addr_n = state_n == RD_LO ? ADDR_W'(DATA_LOW_ADDR) :
                  state_n == RD_HI ? ADDR_W'(DATA_HIGH_ADDR) :
                  op_n == CLEAR    ? ADDR_W'(RESET_ADDR) :
                  op_n == CAPTURE  ? ADDR_W'(SAMPLE_ADDR) : ADDR_W'(ENABLE_ADDR);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op      <= CLEAR;
      cnt     <= '0;
      lo      <= '0;
      ts_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else begin
      state <= state_n;
      op    <= op_n;
      done  <= fin;
      err   <= timeout;
      if (load) begin
        m_valid <= 1'b1;
        m_addr  <= addr_n;
        m_wdata <= DATA_W'(wbit_n);
        m_wstrb <= rd_n ? '0 : '1;
      end else if (fin || timeout) begin
        m_valid <= 1'b0;
      end
      cnt <= load ? '0 : wait_c ? cnt + 1'b1 : cnt;
      if (xfer_done && state == RD_LO) lo <= m_rdata;
      if (xfer_done && state == RD_HI) ts_data <= {m_rdata, lo};
    end
  end
endmodule

// File: tb/tb_iob_timer_reader.sv
// tb_iob_timer_reader: randomized command stream against a delaying slave, scoreboarded transfers and completions
module tb_iob_timer_reader;
  localparam int TO = 4;
  logic clk = 0, rst = 0, cmd_valid = 0, m_ready = 0;
  logic [1:0] cmd_op = 0;
  logic [31:0] m_rdata = 0;
  logic cmd_ready, done, err, m_valid;
  logic [63:0] ts_data;
  logic [3:0] m_addr, m_wstrb;
  logic [31:0] m_wdata;
  iob_timer_reader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .done(done), .err(err), .ts_data(ts_data), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] a; logic [31:0] w; logic [3:0] s;} xfer_t;
  typedef struct packed {logic e; int c; logic [63:0] ts;} res_t;
  xfer_t xq[$];
  res_t rq[$];
  xfer_t pw, xe;
  res_t re;
  bit pv = 0, mon_on = 1, last_v = 0, prev_hold = 0;
  int compared = 0, mismatched = 0, cyc = 0, xi = 0, wcnt = 0, prev_end = 0;
  int dly[4] = '{0, 0, 0, 0};
  logic [31:0] lo_v = 0, hi_v = 0;
  logic [63:0] ts_m = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Slave: answers each transfer after its programmed number of wait cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (last_v && m_ready) begin xi++; wcnt = 0; end
    m_ready = 0;
    if (!m_valid) wcnt = 0;
    else if (wcnt >= (xi < 4 ? dly[xi] : 0)) begin
      m_ready = 1;
      m_rdata = m_addr == 3 ? lo_v : m_addr == 4 ? hi_v : $urandom;
    end else wcnt++;
    last_v = m_valid;
  end
  always @(negedge clk) begin
    if (!mon_on) pv = 0;
    else begin
      if (pv && m_valid) chk("hold_stable", {m_addr, m_wdata, m_wstrb}, pw);
      pv = m_valid && !m_ready;
      pw = {m_addr, m_wdata, m_wstrb};
      if (m_valid && m_ready) begin
        if (xq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL xfer: unexpected transfer addr %0d, none required", m_addr);
        end else begin
          xe = xq.pop_front();
          chk("xfer", {m_addr, (m_wstrb == 0 ? 32'h0 : m_wdata), m_wstrb}, xe);
        end
      end
      if (done || err) begin
        chk("done_err_excl", done && err, 0);
        if (rq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL result: unexpected done=%0b err=%0b, none required", done, err);
        end else begin
          re = rq.pop_front();
          chk("outcome", {err, done}, re.e ? 2'b10 : 2'b01);
          chk("complete_cycle", cyc, re.c);
          chk("ts_data", ts_data, re.ts);
        end
      end
    end
  end
  task automatic issue(input logic [1:0] op, input int d0, d1, d2, d3,
                       input logic [31:0] lo, hi, input bit hold);
    int t, a, n, e;
    bit to;
    xfer_t x;
    res_t r;
    cmd_op = op;
    cmd_valid = 1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      compared++; mismatched++;
      $display("FAIL accept: cmd_ready stayed 0, required 1");
      cmd_valid = 0;
      return;
    end
    a = cyc;
    if (prev_hold) chk("accept_cycle", a, prev_end + 1);
    dly = '{d0, d1, d2, d3};
    xi = 0; wcnt = 0; lo_v = lo; hi_v = hi;
    n = op == 3 ? 4 : op == 0 ? 2 : 1;
    e = a;
    to = 0;
    for (int i = 0; i < n && !to; i++) begin
      if (dly[i] >= TO) begin e += TO; to = 1; end
      else begin
        x.a = op == 0 ? 4'd0 : op == 3 ? (i < 2 ? 4'd2 : 4'(i + 1)) : 4'd1;
        x.s = i < 2 ? 4'hF : 4'h0;
        x.w = (i == 0 && op != 2) ? 32'd1 : 32'd0;
        xq.push_back(x);
        e += dly[i] + 1;
      end
    end
    e++;
    if (!to && op == 3) ts_m = {hi, lo};
    r.e = to; r.c = e; r.ts = ts_m;
    rq.push_back(r);
    prev_end = e;
    prev_hold = hold;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    cmd_valid = 0;
    prev_hold = 0;
    while (rq.size() > 0 && t < 500) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("result_queue_empty", rq.size(), 0);
    chk("xfer_queue_empty", xq.size(), 0);
  endtask
  initial begin
    int t, d[4];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outputs", {m_addr, m_wdata, m_wstrb, done, err}, 0);
    chk("rst_ts_data", ts_data, 0);
    rst = 1;
    @(posedge clk);
    #1;
    issue(1, 0, 0, 0, 0, 0, 0, 0);
    issue(3, 0, 0, 0, 0, 32'hDEADBEEF, 32'h12, 0);
    issue(3, 3, 3, 3, 3, $urandom, $urandom, 0);
    issue(3, 9, 0, 0, 0, $urandom, $urandom, 0);
    issue(3, 0, 0, 9, 0, $urandom, $urandom, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    issue(0, 1, 2, 0, 0, 0, 0, 1);
    issue(2, 2, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) d[i] = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
      issue(2'($urandom_range(0, 3)), d[0], d[1], d[2], d[3], $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();
    // Asynchronous reset while the low word read is waiting
    mon_on = 0;
    dly = '{0, 0, 3, 0}; xi = 0; wcnt = 0;
    cmd_op = 3;
    cmd_valid = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    cmd_valid = 0;
    t = 0;
    @(negedge clk);
    while (!(m_valid && m_addr == 3) && t < 20) begin @(negedge clk); t++; end
    chk("reached_rd_lo", {m_valid, m_addr}, {1'b1, 4'd3});
    #2 rst = 0;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_ts_data", ts_data, 0);
    chk("async_cmd_ready", cmd_ready, 1);
    chk("async_outputs", {m_addr, m_wdata, m_wstrb, done, err}, 0);
    @(negedge clk);
    rst = 1;
    ts_m = 0;
    mon_on = 1;
    @(posedge clk);
    #1;
    issue(1, 0, 0, 0, 0, 0, 0, 0);
    issue(3, 1, 0, 2, 0, $urandom, $urandom, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
